// File: rtl/sync_ram_block.sv
// sync_ram_block: single-port synchronous RAM with registered read data.
// Depth is 2**ADDR_WIDTH words of DATA_WIDTH bits. Writes are write-first.
// Reset clears every word and the output register in a single edge.
//
// Ports:
//   clk   rising-edge clock, sole clock of the block
//   rst   synchronous active-high reset; clears all words and dout
//   we    write enable: 1 = write din to mem[addr] this edge
//   addr  word address shared by write and read
//   din   write data
//   dout  registered read data, valid one cycle after addr
module sync_ram_block #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;

    // A plain if (we) keeps an X on we from writing anywhere in simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else if (we) begin
            mem_q[addr] <= din;
            // Write-first: the written word appears on dout immediately.
            dout_q      <= din;
        end else begin
            dout_q <= mem_q[addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_sync_ram_block.sv
// tb_sync_ram_block: directed plus randomized checks of sync_ram_block against
// an array-based reference model of the RAM contents.
module tb_sync_ram_block;

    logic       clk;
    logic       rst;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    int unsigned n_cmp;
    int unsigned n_err;

    // Reference model
    logic [7:0] ref_mem [16];
    logic [7:0] ref_dout;
    bit         model_valid;

    sync_ram_block #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .addr(addr),
        .din (din),
        .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: dout=%02h expected=%02h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply inputs, confirm dout does not follow them combinationally,
    // then let the edge happen and compare against the model.
    task automatic step(input string tag, input logic r, input logic w,
                        input logic [3:0] a, input logic [7:0] d);
        rst  = r;
        we   = w;
        addr = a;
        din  = d;
        #2;
        if (model_valid) check_eq({tag, " hold"}, dout, ref_dout);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
            ref_dout    = 8'h00;
            model_valid = 1'b1;
        end else if (w) begin
            ref_mem[a] = d;
            ref_dout   = d;
        end else begin
            ref_dout = ref_mem[a];
        end
        #1;
        if (model_valid) check_eq(tag, dout, ref_dout);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        model_valid = 1'b0;
        ref_dout    = 8'h00;
        rst         = 1'b1;
        we          = 1'b0;
        addr        = '0;
        din         = '0;

        // 1. Reset, then every address reads zero.
        step("reset0", 1'b1, 1'b0, 4'd0, 8'h00);
        step("reset1", 1'b1, 1'b0, 4'd0, 8'h00);
        for (int a = 0; a < 16; a++) step("rst_read", 1'b0, 1'b0, 4'(a), 8'h00);
        check_eq("rst_read_lit", dout, 8'h00);

        // 2. Write then read back.
        step("wr1", 1'b0, 1'b1, 4'd1, 8'hAA);
        step("wr2", 1'b0, 1'b1, 4'd2, 8'h55);
        step("rd1", 1'b0, 1'b0, 4'd1, 8'h00);
        check_eq("rd1_lit", dout, 8'hAA);
        step("rd2", 1'b0, 1'b0, 4'd2, 8'h00);
        check_eq("rd2_lit", dout, 8'h55);

        // 3. Write-first.
        step("wf7", 1'b0, 1'b1, 4'd7, 8'h3C);
        check_eq("wf7_lit", dout, 8'h3C);
        step("rd7", 1'b0, 1'b0, 4'd7, 8'h00);

        // 4. Address boundaries.
        step("wr15", 1'b0, 1'b1, 4'd15, 8'hFF);
        step("wr0", 1'b0, 1'b1, 4'd0, 8'h01);
        step("rd15", 1'b0, 1'b0, 4'd15, 8'h00);
        check_eq("rd15_lit", dout, 8'hFF);
        step("rd0", 1'b0, 1'b0, 4'd0, 8'h00);
        check_eq("rd0_lit", dout, 8'h01);
        step("rd14", 1'b0, 1'b0, 4'd14, 8'h00);
        check_eq("rd14_lit", dout, 8'h00);

        // 5. Reset with a write pending must clear everything and write nothing.
        for (int a = 0; a < 16; a++) step("fill", 1'b0, 1'b1, 4'(a), 8'(a) ^ 8'hA5);
        step("rst_we", 1'b1, 1'b1, 4'd3, 8'h99);
        check_eq("rst_we_lit", dout, 8'h00);
        for (int a = 0; a < 16; a++) step("post_rst", 1'b0, 1'b0, 4'(a), 8'h00);

        // 6. Overwrite and back-to-back reads.
        step("ow12", 1'b0, 1'b1, 4'd5, 8'h12);
        step("ow34", 1'b0, 1'b1, 4'd5, 8'h34);
        step("rd5a", 1'b0, 1'b0, 4'd5, 8'h00);
        check_eq("rd5a_lit", dout, 8'h34);
        step("rd6", 1'b0, 1'b0, 4'd6, 8'h00);
        check_eq("rd6_lit", dout, 8'h00);
        step("rd5b", 1'b0, 1'b0, 4'd5, 8'h00);
        check_eq("rd5b_lit", dout, 8'h34);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            step("rand",
                 ($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
